// File: rtl/mux_arbiter_if.sv
// mux_arbiter_if: bundle between the two requesters and the arbiter that
// owns the shared data mux.
//
// Handshake: reqX is a level. A requester holds it high for as long as it
// wants the mux. gntX is registered and means requester X owns the mux for
// the current cycle. There is no separate ready: valid marks that data_out
// carries the owner's word for that cycle, and sel names the owner.
//
// Signals:
//   req0, req1      requester -> arbiter, request levels
//   data0, data1    requester -> arbiter, data words
//   gnt0, gnt1      arbiter -> requester, registered grants (one-hot or zero)
//   sel             arbiter -> mux, registered select (holds while idle)
//   data_out        arbiter -> sink, registered owner data
//   valid           arbiter -> sink, data_out is owner data this cycle
//   state_dbg       arbiter -> observer, FSM state (0 idle, 1 own0, 2 own1)
interface mux_arbiter_if #(
  parameter int WIDTH = 2
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic [1:0]       state_dbg;

  modport master (
    output req0, req1, data0, data1,
    input  gnt0, gnt1, sel, data_out, valid, state_dbg
  );

  modport slave (
    input  req0, req1, data0, data1,
    output gnt0, gnt1, sel, data_out, valid, state_dbg
  );
endinterface

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter that owns the select line
// of the shared data mux. It registers the grants, the select and the
// selected data word. A hold limit forces a switch after MAX_HOLD cycles
// while the other requester is waiting.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    mux_arbiter_if slave modport (requests/data in, grants/sel/data out)
module mux_arbiter #(
  parameter int WIDTH    = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           reset,
  mux_arbiter_if.slave   bus
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state;
  state_t           nxt;
  logic             prio;
  logic [HW-1:0]    hold_cnt;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             sel_q;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Arbitration decision for the coming edge.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) nxt = prio ? OWN1 : OWN0;
        else if (bus.req0)        nxt = OWN0;
        else if (bus.req1)        nxt = OWN1;
        else                      nxt = IDLE;
      end
      OWN0: begin
        if (!bus.req0)                         nxt = bus.req1 ? OWN1 : IDLE;
        else if (bus.req1 && hold_cnt == HOLD_MAX) nxt = OWN1;
        else                                   nxt = OWN0;
      end
      OWN1: begin
        if (!bus.req1)                         nxt = bus.req0 ? OWN0 : IDLE;
        else if (bus.req0 && hold_cnt == HOLD_MAX) nxt = OWN0;
        else                                   nxt = OWN1;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prio     <= 1'b0;
      hold_cnt <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      sel_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state <= nxt;

      // Entering an owner state restarts the hold count and hands the
      // tie-break to the other requester; staying counts up to saturation.
      if (nxt != IDLE && nxt != state) begin
        hold_cnt <= HW'(1);
        prio     <= (nxt == OWN0);
      end else if (nxt != IDLE && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HW'(1);
      end

      // Outputs follow the state being entered, so they are valid one
      // register stage after the request is sampled.
      case (nxt)
        OWN0: begin
          gnt0_q  <= 1'b1;
          gnt1_q  <= 1'b0;
          sel_q   <= 1'b0;
          valid_q <= 1'b1;
          data_q  <= bus.data0;
        end
        OWN1: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b1;
          sel_q   <= 1'b1;
          valid_q <= 1'b1;
          data_q  <= bus.data1;
        end
        default: begin
          // sel keeps its last value so the mux does not glitch while idle.
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          valid_q <= 1'b0;
          data_q  <= '0;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.sel       = sel_q;
  assign bus.valid     = valid_q;
  assign bus.data_out  = data_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: self-checking bench for mux_arbiter. A behavioural model
// predicts the registered outputs for each driven cycle; predictions are
// queued when stimulus is applied and compared after the clock edge.
module tb_mux_arbiter;

  localparam int WIDTH    = 2;
  localparam int MAX_HOLD = 4;
  localparam int VW       = 4 + WIDTH;

  logic clk = 1'b0;
  logic reset;

  mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [VW-1:0] exp_q[$];

  // Reference model state.
  int               m_owner = -1;
  int               m_cnt   = 0;
  int               m_prio  = 0;
  logic             m_sel   = 1'b0;
  logic [WIDTH-1:0] prev_d0;
  logic [WIDTH-1:0] prev_d1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] model_step(input logic rst, input logic r0, input logic r1,
                                               input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    int nw;
    logic mine, other;
    logic [WIDTH-1:0] d;
    if (rst) begin
      m_owner = -1;
      m_prio  = 0;
      m_cnt   = 0;
      m_sel   = 1'b0;
    end else begin
      if (m_owner < 0) begin
        if (r0 && r1) nw = m_prio;
        else if (r0)  nw = 0;
        else if (r1)  nw = 1;
        else          nw = -1;
      end else begin
        mine  = (m_owner == 0) ? r0 : r1;
        other = (m_owner == 0) ? r1 : r0;
        if (!mine)                          nw = other ? 1 - m_owner : -1;
        else if (other && m_cnt == MAX_HOLD) nw = 1 - m_owner;
        else                                nw = m_owner;
      end
      if (nw >= 0 && nw != m_owner) begin
        m_cnt  = 1;
        m_prio = 1 - nw;
      end else if (nw >= 0 && m_cnt < MAX_HOLD) begin
        m_cnt = m_cnt + 1;
      end
      m_owner = nw;
      if (nw >= 0) m_sel = (nw == 1);
    end
    d = (m_owner == 0) ? d0 : (m_owner == 1) ? d1 : '0;
    return {m_owner == 0, m_owner == 1, m_sel, m_owner >= 0, d};
  endfunction

  // Drive one cycle, predict, wait for the edge and compare against the queue.
  task automatic step(input logic rst, input logic r0, input logic r1,
                      input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    logic [VW-1:0] got;
    logic [VW-1:0] exp;
    reset    = rst;
    bus.req0 = r0;
    bus.req1 = r1;
    bus.data0 = d0;
    bus.data1 = d1;
    prev_d0  = d0;
    prev_d1  = d1;
    exp_q.push_back(model_step(rst, r0, r1, d0, d1));
    @(posedge clk);
    #1;
    got = {bus.gnt0, bus.gnt1, bus.sel, bus.valid, bus.data_out};
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check("sb", 32'(got), 32'(exp));
    end
  endtask

  initial begin
    logic r0, r1;
    reset    = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.data0 = '0;
    bus.data1 = '0;

    // Reset then idle.
    step(1, 0, 0, 2'b11, 2'b11);
    step(1, 0, 0, 2'b11, 2'b11);
    check("rst_outs", {28'd0, bus.gnt0, bus.gnt1, bus.sel, bus.valid}, 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    step(0, 0, 0, 2'b01, 2'b10);
    step(0, 0, 0, 2'b01, 2'b10);
    check("idle_outs", {28'd0, bus.gnt0, bus.gnt1, bus.sel, bus.valid}, 32'd0);

    // Single requester 1 with changing data, then release.
    step(0, 0, 1, 2'b00, 2'b10);
    check("single_gnt1", {29'd0, bus.gnt1, bus.sel, bus.valid}, 32'h7);
    check("single_d0", 32'(bus.data_out), 32'h2);
    step(0, 0, 1, 2'b00, 2'b01);
    check("single_d1", 32'(bus.data_out), 32'h1);
    step(0, 0, 0, 2'b00, 2'b11);
    check("release_data", 32'(bus.data_out), 32'h0);
    check("release_sel", 32'(bus.sel), 32'h1);
    check("release_valid", 32'(bus.valid), 32'h0);

    // Reset during OWN1.
    step(0, 0, 1, 2'b00, 2'b11);
    step(0, 0, 1, 2'b00, 2'b11);
    step(1, 0, 1, 2'b00, 2'b11);
    check("rst_mid_grant", {28'd0, bus.gnt0, bus.gnt1, bus.sel, bus.valid}, 32'd0);
    check("rst_mid_data", 32'(bus.data_out), 32'd0);

    // Tie out of reset: strict alternation of MAX_HOLD bursts.
    step(1, 0, 0, 2'b00, 2'b00);
    for (int i = 0; i < 4 * MAX_HOLD; i++) begin
      step(0, 1, 1, 2'(i), 2'(~i));
      check("tie_gnt0", 32'(bus.gnt0), 32'(((i / MAX_HOLD) % 2) == 0));
      check("tie_valid", 32'(bus.valid), 32'd1);
    end

    // Early release with requester 1 waiting: no idle cycle.
    step(1, 0, 0, 2'b00, 2'b00);
    step(0, 1, 1, 2'b01, 2'b10);
    step(0, 1, 1, 2'b01, 2'b10);
    check("early_own0", 32'(bus.gnt0), 32'd1);
    step(0, 0, 1, 2'b01, 2'b11);
    check("early_gnt1", {29'd0, bus.gnt1, bus.sel, bus.valid}, 32'h7);
    check("early_data", 32'(bus.data_out), 32'h3);

    // Saturation: long solo ownership, then contention switches at once.
    step(1, 0, 0, 2'b00, 2'b00);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 2'b01, 2'b10);
    check("sat_own0", 32'(bus.gnt0), 32'd1);
    step(0, 1, 1, 2'b01, 2'b10);
    check("sat_switch", 32'(bus.gnt1), 32'd1);
    for (int i = 0; i < MAX_HOLD - 1; i++) step(0, 1, 1, 2'b01, 2'b10);
    check("sat_hold1", 32'(bus.gnt1), 32'd1);
    step(0, 1, 1, 2'b01, 2'b10);
    check("sat_back0", 32'(bus.gnt0), 32'd1);

    // Random traffic with invariant checks.
    r0 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) r0 = ~r0;
      if ($urandom_range(0, 3) == 0) r1 = ~r1;
      step(($urandom_range(0, 99) == 0), r0, r1,
           WIDTH'($urandom_range(0, 3)), WIDTH'($urandom_range(0, 3)));
      check("excl", 32'(bus.gnt0 & bus.gnt1), 32'd0);
      if (bus.valid) begin
        check("sel_owner", 32'(bus.sel), 32'(bus.gnt1));
        check("data_prev", 32'(bus.data_out), 32'(bus.gnt0 ? prev_d0 : prev_d1));
      end
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
